// File: rtl/tl_addr_demux_pkg.sv
// TL-UL channel types, the xbar device address map, and the types/helpers local to the address demux.
// The three packages share this file so that they always compile before the RTL that imports them.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

package xbar_pkg;

    typedef enum int unsigned {
        TlDccm, TlIccm, TlGpio, TlUart, TlTimer, TlSpi, TlI2c,
        TlPwm, TlHmac, TlAes, TlPlic, TlFlash, TlRom
    } tl_device_e;

    localparam int unsigned N_DEVICE = 13;

    localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

    // Listed from the highest index (TlRom) down to index 0 (TlDccm).
    localparam logic [N_DEVICE-1:0][31:0] ADDR_SPACE = {
        32'h0000_8000, 32'h4009_0000, 32'h4007_0000, 32'h4005_0000,
        32'h4004_0000, 32'h4003_0000, 32'h4002_0000, 32'h4001_0000,
        32'h4000_0000, 32'h4006_0000, 32'h4008_0000, 32'h2000_0000,
        32'h1000_0000
    };

    localparam logic [N_DEVICE-1:0][31:0] ADDR_MASK = {
        32'h0000_3FFF, 32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF,
        32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF,
        32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_FFFF,
        32'h0000_FFFF
    };

endpackage

package tl_addr_demux_pkg;

    typedef enum logic {
        ErrIdle = 1'b0,
        ErrResp = 1'b1
    } err_state_e;

    // Mask bits mark the offset inside a device window; only the remaining bits identify the device.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & ~mask) == (base & ~mask);
    endfunction

endpackage

// File: rtl/tl_addr_demux_err.sv
// tl_err_resp: single-entry TL-UL error responder that answers every request it accepts
// with d_error set and all-ones data.
module tl_err_resp
    import tlul_pkg::*;
    import tl_addr_demux_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o
);

    err_state_e  state_q;
    err_state_e  state_d;
    tl_a_op_e    op_q;
    logic [7:0]  source_q;
    logic [1:0]  size_q;
    logic        unused_fields;

    assign unused_fields = ^{tl_i.a_param, tl_i.a_address, tl_i.a_mask, tl_i.a_data};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ErrIdle;
            op_q     <= Get;
            source_q <= '0;
            size_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ErrIdle && tl_i.a_valid) begin
                op_q     <= tl_i.a_opcode;
                source_q <= tl_i.a_source;
                size_q   <= tl_i.a_size;
            end
        end
    end

    // Outputs depend on the state only, so the response stays stable until d_ready.
    always_comb begin
        state_d = state_q;
        tl_o    = '0;
        case (state_q)
            ErrIdle: begin
                tl_o.a_ready = 1'b1;
                if (tl_i.a_valid) begin
                    state_d = ErrResp;
                end
            end
            ErrResp: begin
                tl_o.d_valid  = 1'b1;
                tl_o.d_error  = 1'b1;
                tl_o.d_data   = xbar_pkg::ERR_DATA;
                tl_o.d_source = source_q;
                tl_o.d_size   = size_q;
                tl_o.d_opcode = (op_q == Get) ? AccessAckData : AccessAck;
                if (tl_i.d_ready) begin
                    state_d = ErrIdle;
                end
            end
            default: state_d = ErrIdle;
        endcase
    end

endmodule

// File: rtl/tl_addr_demux.sv
// tl_addr_demux: 1-host to NDev-device TL-UL address demux with in-order outstanding tracking,
// an error responder for unmapped addresses and a saturating unmapped-access counter.
module tl_addr_demux
    import tlul_pkg::*;
    import tl_addr_demux_pkg::*;
#(
    parameter int unsigned            NDev      = 13,
    parameter int unsigned            MaxOutstd = 4,
    parameter logic [NDev-1:0][31:0]  AddrSpace = xbar_pkg::ADDR_SPACE,
    parameter logic [NDev-1:0][31:0]  AddrMask  = xbar_pkg::ADDR_MASK
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  tl_h2d_t     tl_h_i,
    output tl_d2h_t     tl_h_o,
    output tl_h2d_t     tl_d_o [NDev],
    input  tl_d2h_t     tl_d_i [NDev],
    output logic [15:0] unmapped_cnt_o,
    output logic        busy_o
);

    localparam int unsigned     OutW   = $clog2(MaxOutstd + 1);
    localparam int unsigned     TgtW   = $clog2(NDev + 1);
    localparam logic [TgtW-1:0] ErrTgt = TgtW'(NDev);
    localparam logic [OutW-1:0] OutMax = OutW'(MaxOutstd);

    logic [OutW-1:0] outstd_q;
    logic [TgtW-1:0] tgt_q;
    logic [TgtW-1:0] dec_tgt;
    logic [15:0]     unmapped_cnt_q;
    logic            stall;
    logic            sel_ready;
    logic            accept;
    logic            d_hs;
    tl_h2d_t         err_req;
    tl_d2h_t         err_rsp;
    tl_d2h_t         rsp_sel;

    // Scanning downward lets the lowest matching index overwrite any higher match.
    always_comb begin
        dec_tgt = ErrTgt;
        for (int i = int'(NDev) - 1; i >= 0; i--) begin
            if (addr_hit(tl_h_i.a_address, AddrSpace[i], AddrMask[i])) begin
                dec_tgt = TgtW'(i);
            end
        end
    end

    // Only one target may have requests in flight, which keeps responses ordered without a reorder buffer.
    assign stall = (outstd_q == OutMax) || ((outstd_q != '0) && (dec_tgt != tgt_q));

    always_comb begin
        for (int i = 0; i < int'(NDev); i++) begin
            tl_d_o[i]         = tl_h_i;
            tl_d_o[i].a_valid = tl_h_i.a_valid && !stall && (dec_tgt == TgtW'(i));
            tl_d_o[i].d_ready = tl_h_i.d_ready && (tgt_q == TgtW'(i));
        end
        err_req         = tl_h_i;
        err_req.a_valid = tl_h_i.a_valid && !stall && (dec_tgt == ErrTgt);
        err_req.d_ready = tl_h_i.d_ready && (tgt_q == ErrTgt);
    end

    always_comb begin
        sel_ready = err_rsp.a_ready;
        rsp_sel   = err_rsp;
        for (int i = 0; i < int'(NDev); i++) begin
            if (dec_tgt == TgtW'(i)) begin
                sel_ready = tl_d_i[i].a_ready;
            end
            if (tgt_q == TgtW'(i)) begin
                rsp_sel = tl_d_i[i];
            end
        end
        tl_h_o         = rsp_sel;
        tl_h_o.d_valid = rsp_sel.d_valid && (outstd_q != '0);
        tl_h_o.a_ready = sel_ready && !stall;
    end

    assign accept = tl_h_i.a_valid && tl_h_o.a_ready;
    assign d_hs   = tl_h_o.d_valid && tl_h_i.d_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstd_q       <= '0;
            tgt_q          <= '0;
            unmapped_cnt_q <= '0;
        end else begin
            if (accept) begin
                tgt_q <= dec_tgt;
            end
            if (accept && !d_hs) begin
                outstd_q <= outstd_q + OutW'(1);
            end else if (!accept && d_hs) begin
                outstd_q <= outstd_q - OutW'(1);
            end
            if (accept && (dec_tgt == ErrTgt) && (unmapped_cnt_q != 16'hFFFF)) begin
                unmapped_cnt_q <= unmapped_cnt_q + 16'd1;
            end
        end
    end

    assign unmapped_cnt_o = unmapped_cnt_q;
    assign busy_o         = (outstd_q != '0);

    tl_err_resp u_err (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tl_i   (err_req),
        .tl_o   (err_rsp)
    );

    outstd_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni) outstd_q <= OutMax);

endmodule

// File: tb/tb_tl_addr_demux.sv
// Self-checking bench for tl_addr_demux: directed scenarios plus randomized single transactions
// whose target is predicted from an address-range table.
module tb_tl_addr_demux;
    import tlul_pkg::*;

    localparam int NDEV = 13;
    localparam int MAXO = 4;

    // Device windows as base/size ranges, index order 0..12.
    localparam logic [31:0] DEV_BASE [NDEV] = '{
        32'h1000_0000, 32'h2000_0000, 32'h4008_0000, 32'h4006_0000, 32'h4000_0000,
        32'h4001_0000, 32'h4002_0000, 32'h4003_0000, 32'h4004_0000, 32'h4005_0000,
        32'h4007_0000, 32'h4009_0000, 32'h0000_8000
    };
    localparam logic [31:0] DEV_SIZE [NDEV] = '{
        32'h1_0000, 32'h1_0000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000,
        32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h4000
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    tl_h2d_t     host_req;
    tl_d2h_t     host_rsp;
    tl_h2d_t     dev_req [NDEV];
    tl_d2h_t     dev_rsp [NDEV];
    logic [15:0] unmapped_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    tl_addr_demux #(.NDev(NDEV), .MaxOutstd(MAXO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tl_h_i         (host_req),
        .tl_h_o         (host_rsp),
        .tl_d_o         (dev_req),
        .tl_d_i         (dev_rsp),
        .unmapped_cnt_o (unmapped_cnt),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_target(input logic [31:0] a);
        for (int j = 0; j < NDEV; j++) begin
            if (a >= DEV_BASE[j] && (a - DEV_BASE[j]) < DEV_SIZE[j]) return j;
        end
        return NDEV;
    endfunction

    function automatic logic [31:0] a_valid_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NDEV; i++) v[i] = dev_req[i].a_valid;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input tl_a_op_e op, input logic [7:0] src);
        host_req.a_valid   = 1'b1;
        host_req.a_address = addr;
        host_req.a_opcode  = op;
        host_req.a_source  = src;
        host_req.a_size    = 2'd2;
        host_req.a_mask    = 4'hF;
        host_req.a_data    = $urandom();
        #1;
    endtask

    task automatic devRespond(input int j, input logic [31:0] data, input logic [7:0] src);
        dev_rsp[j].d_valid  = 1'b1;
        dev_rsp[j].d_data   = data;
        dev_rsp[j].d_source = src;
        dev_rsp[j].d_opcode = AccessAckData;
        dev_rsp[j].d_error  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  src;
        tl_a_op_e    op;
        int          kind;
        int          j;
        int          exp_t;
        int          waits;

        host_req = '0;
        for (int i = 0; i < NDEV; i++) begin
            dev_rsp[i] = '0;
            dev_rsp[i].a_ready = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_dvalid", host_rsp.d_valid, 0);
        checkOutput("rst_cnt", unmapped_cnt, 0);
        checkOutput("rst_avec", a_valid_vec(), 0);
        rst_n = 1'b1;
        tick();

        // GPIO get: only device 2 sees the request; its data comes back to the host.
        applyStimulus(32'h4008_0010, Get, 8'd1);
        checkOutput("gpio_avec", a_valid_vec(), 32'h4);
        checkOutput("gpio_aready", host_rsp.a_ready, 1);
        tick();
        host_req.a_valid = 1'b0;
        #1;
        checkOutput("gpio_busy", busy, 1);
        devRespond(2, 32'h1234, 8'd1);
        host_req.d_ready = 1'b1;
        #1;
        checkOutput("gpio_dvalid", host_rsp.d_valid, 1);
        checkOutput("gpio_ddata", host_rsp.d_data, 32'h1234);
        checkOutput("gpio_dready_route", dev_req[2].d_ready, 1);
        tick();
        dev_rsp[2].d_valid = 1'b0;
        #1;
        checkOutput("gpio_busy_drop", busy, 0);

        // Unmapped get answered by the error responder one cycle after accept.
        host_req.d_ready = 1'b0;
        applyStimulus(32'h5000_0000, Get, 8'd3);
        checkOutput("umg_avec", a_valid_vec(), 0);
        checkOutput("umg_aready", host_rsp.a_ready, 1);
        tick();
        exp_cnt++;
        host_req.a_valid = 1'b0;
        #1;
        checkOutput("umg_dvalid", host_rsp.d_valid, 1);
        checkOutput("umg_derror", host_rsp.d_error, 1);
        checkOutput("umg_dopcode", host_rsp.d_opcode, AccessAckData);
        checkOutput("umg_ddata", host_rsp.d_data, 32'hFFFF_FFFF);
        checkOutput("umg_dsource", host_rsp.d_source, 3);
        checkOutput("umg_cnt", unmapped_cnt, exp_cnt);
        host_req.d_ready = 1'b1;
        tick();
        checkOutput("umg_busy_drop", busy, 0);
        checkOutput("umg_dvalid_drop", host_rsp.d_valid, 0);

        // Unmapped put with d_ready withheld: response stays stable and the responder is not ready.
        host_req.d_ready = 1'b0;
        applyStimulus(32'h4010_0000, PutFullData, 8'd5);
        checkOutput("ump_aready", host_rsp.a_ready, 1);
        tick();
        exp_cnt++;
        host_req.a_valid = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("ump_dvalid", host_rsp.d_valid, 1);
            checkOutput("ump_dopcode", host_rsp.d_opcode, AccessAck);
            checkOutput("ump_derror", host_rsp.d_error, 1);
            checkOutput("ump_dsource", host_rsp.d_source, 5);
            checkOutput("ump_aready_low", host_rsp.a_ready, 0);
            tick();
        end
        checkOutput("ump_cnt", unmapped_cnt, exp_cnt);
        host_req.d_ready = 1'b1;
        tick();
        checkOutput("ump_busy_drop", busy, 0);

        // Back-to-back DCCM gets with responses withheld: four fit, the fifth stalls.
        applyStimulus(32'h1000_0000, Get, 8'd7);
        for (int k = 0; k < MAXO; k++) begin
            checkOutput("b2b_accept", host_rsp.a_ready, 1);
            tick();
        end
        checkOutput("b2b_full_aready", host_rsp.a_ready, 0);
        checkOutput("b2b_full_avec", a_valid_vec(), 0);
        tick();
        devRespond(0, 32'hD0D0_0000, 8'd7);
        #1;
        checkOutput("b2b_hs_only_aready", host_rsp.a_ready, 0);
        checkOutput("b2b_hs_only_dvalid", host_rsp.d_valid, 1);
        tick();
        checkOutput("b2b_after_hs_aready", host_rsp.a_ready, 1);
        tick();
        dev_rsp[0].d_valid = 1'b0;
        #1;
        checkOutput("b2b_both_kept_count", host_rsp.a_ready, 1);
        tick();
        checkOutput("b2b_refull_aready", host_rsp.a_ready, 0);
        checkOutput("b2b_refull_busy", busy, 1);
        host_req.a_valid = 1'b0;
        dev_rsp[0].d_valid = 1'b1;
        #1;
        for (int k = 0; k < MAXO; k++) begin
            checkOutput("b2b_drain_dvalid", host_rsp.d_valid, 1);
            tick();
        end
        checkOutput("b2b_drain_busy", busy, 0);
        checkOutput("b2b_stray_dvalid", host_rsp.d_valid, 0);
        dev_rsp[0].d_valid = 1'b0;

        // Target switch: UART request waits for the outstanding ICCM response.
        applyStimulus(32'h2000_0000, Get, 8'd9);
        checkOutput("sw_iccm_aready", host_rsp.a_ready, 1);
        tick();
        applyStimulus(32'h4006_0000, Get, 8'd10);
        for (int k = 0; k < 2; k++) begin
            checkOutput("sw_stall_aready", host_rsp.a_ready, 0);
            checkOutput("sw_stall_avec", a_valid_vec(), 0);
            tick();
        end
        devRespond(1, 32'hCAFE_0001, 8'd9);
        #1;
        checkOutput("sw_iccm_ddata", host_rsp.d_data, 32'hCAFE_0001);
        checkOutput("sw_iccm_aready_low", host_rsp.a_ready, 0);
        tick();
        dev_rsp[1].d_valid = 1'b0;
        #1;
        checkOutput("sw_uart_avec", a_valid_vec(), 32'h8);
        checkOutput("sw_uart_aready", host_rsp.a_ready, 1);
        tick();
        host_req.a_valid = 1'b0;
        devRespond(3, 32'h0000_0A5A, 8'd10);
        #1;
        checkOutput("sw_uart_dsource", host_rsp.d_source, 10);
        tick();
        dev_rsp[3].d_valid = 1'b0;
        #1;
        checkOutput("sw_busy_drop", busy, 0);

        // Randomized single transactions against the range model.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            j = $urandom_range(0, NDEV - 1);
            case (kind)
                0:       addr = $urandom();
                3:       addr = DEV_BASE[j] + DEV_SIZE[j];
                default: addr = DEV_BASE[j] + $urandom_range(0, DEV_SIZE[j] - 1);
            endcase
            addr[1:0] = 2'b00;
            exp_t = ref_target(addr);
            src = 8'($urandom());
            op = ($urandom_range(0, 1) == 1) ? Get : PutFullData;
            waits = (exp_t < NDEV) ? $urandom_range(0, 2) : 0;
            if (waits > 0) dev_rsp[exp_t].a_ready = 1'b0;
            applyStimulus(addr, op, src);
            for (int k = 0; k < waits; k++) begin
                checkOutput("rnd_wait_aready", host_rsp.a_ready, 0);
                tick();
            end
            if (exp_t < NDEV) dev_rsp[exp_t].a_ready = 1'b1;
            #1;
            checkOutput("rnd_avec", a_valid_vec(), (exp_t < NDEV) ? (32'h1 << exp_t) : 32'h0);
            checkOutput("rnd_aready", host_rsp.a_ready, 1);
            tick();
            host_req.a_valid = 1'b0;
            if (exp_t < NDEV) begin
                data = $urandom();
                devRespond(exp_t, data, src);
                #1;
                checkOutput("rnd_dev_ddata", host_rsp.d_data, data);
                checkOutput("rnd_dev_derror", host_rsp.d_error, 0);
            end else begin
                exp_cnt = (exp_cnt < 16'hFFFF) ? exp_cnt + 1 : exp_cnt;
                #1;
                checkOutput("rnd_err_derror", host_rsp.d_error, 1);
                checkOutput("rnd_err_ddata", host_rsp.d_data, 32'hFFFF_FFFF);
                checkOutput("rnd_err_dsource", host_rsp.d_source, src);
                checkOutput("rnd_err_dopcode", host_rsp.d_opcode, (op == Get) ? AccessAckData : AccessAck);
            end
            checkOutput("rnd_dvalid", host_rsp.d_valid, 1);
            tick();
            if (exp_t < NDEV) dev_rsp[exp_t].d_valid = 1'b0;
            #1;
            checkOutput("rnd_busy", busy, 0);
            checkOutput("rnd_cnt", unmapped_cnt, exp_cnt);
        end

        // Saturation: start the counter just below the top instead of replaying 65536 accesses.
        force dut.unmapped_cnt_q = 16'hFFFC;
        #1;
        release dut.unmapped_cnt_q;
        exp_cnt = 16'hFFFC;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(32'h5000_0000, Get, 8'd4);
            tick();
            host_req.a_valid = 1'b0;
            exp_cnt = (exp_cnt < 16'hFFFF) ? exp_cnt + 1 : exp_cnt;
            #1;
            checkOutput("sat_cnt", unmapped_cnt, exp_cnt);
            tick();
        end

        // Reset while the error responder is answering.
        host_req.d_ready = 1'b0;
        applyStimulus(32'h5000_0000, Get, 8'd2);
        tick();
        host_req.a_valid = 1'b0;
        #1;
        checkOutput("rstmid_pre_dvalid", host_rsp.d_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_dvalid", host_rsp.d_valid, 0);
        checkOutput("rstmid_cnt", unmapped_cnt, 0);
        checkOutput("rstmid_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        #1;
        applyStimulus(32'h5000_0000, Get, 8'd2);
        checkOutput("rstmid_err_idle", host_rsp.a_ready, 1);
        host_req.a_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
